// File: rtl/card_rom_arbiter_if.sv
// card_rom_arbiter_if: requester/ROM bus bundle shared by the card ROM arbiter and its users
interface card_rom_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 15,
   parameter int DATA_W = 12
);
   logic [N_REQ-1:0]        req;
   logic [N_REQ*ADDR_W-1:0] addr;
   logic                    vblank;
   logic [N_REQ-1:0]        gnt;
   logic [ADDR_W-1:0]       rom_addr;
   logic [DATA_W-1:0]       rom_data;
   logic [DATA_W-1:0]       rdata;
   logic [N_REQ-1:0]        rvalid;
   modport master (output req, addr, vblank, rom_data, input gnt, rom_addr, rdata, rvalid);
   modport slave  (input req, addr, vblank, rom_data, output gnt, rom_addr, rdata, rvalid);
endinterface

// File: rtl/card_rom_arbiter.sv
// card_rom_arbiter: round-robin burst arbiter for the shared card ROM; ARB_VBLANK_PRIO_EN gives requester 0 vblank priority
module card_rom_arbiter #(
   parameter int N_REQ     = 4,
   parameter int ADDR_W    = 15,
   parameter int DATA_W    = 12,
   parameter int MAX_BURST = 16
) (
   input logic             clk,
   input logic             rst_n,
   card_rom_arbiter_if.slave bus
);
   localparam int PW = $clog2(N_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;
   localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};
   logic [0:0]        state;
   logic [PW-1:0]     owner;
   logic [PW-1:0]     ptr;
   logic [PW-1:0]     win;
   logic              found;
   logic [CW-1:0]     burst_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [N_REQ-1:0]  beat_d1;
   logic              beat;
   logic              at_limit;
   logic              rearb;
   logic              prio;
   logic              no_limit;
`ifdef ARB_VBLANK_PRIO_EN
   assign prio     = bus.vblank && bus.req[0];
   assign no_limit = bus.vblank && owner == '0;
`else
   logic unused_vblank;
   assign unused_vblank = bus.vblank;
   assign prio          = 1'b0;
   assign no_limit      = 1'b0;
`endif
   assign beat         = state == BUSY && bus.req[owner];
   assign at_limit     = burst_cnt == CW'(MAX_BURST - 1);
   assign rearb        = state == IDLE || !bus.req[owner] || (beat && at_limit && !no_limit);
   assign bus.rom_addr = beat ? bus.addr[owner*ADDR_W +: ADDR_W] : addr_q;
   // pick the first requester at or after ptr; downward scan lets the closest one win
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (bus.req[(int'(ptr) + k) % N_REQ]) begin
            win   = PW'((int'(ptr) + k) % N_REQ);
            found = 1'b1;
         end
      end
      if (prio) begin
         win   = '0;
         found = 1'b1;
      end
   end
   // grant state, burst counting and the two-stage read-return pipeline
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= '0;
         ptr        <= '0;
         burst_cnt  <= '0;
         addr_q     <= '0;
         beat_d1    <= '0;
         bus.gnt    <= '0;
         bus.rvalid <= '0;
         bus.rdata  <= '0;
      end else begin
         addr_q     <= bus.rom_addr;
         beat_d1    <= beat ? ONE << owner : '0;
         bus.rvalid <= beat_d1;
         if (|beat_d1) bus.rdata <= bus.rom_data;
         if (rearb) begin
            state     <= found ? BUSY : IDLE;
            bus.gnt   <= found ? ONE << win : '0;
            burst_cnt <= '0;
            if (found) begin
               owner <= win;
               ptr   <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
            end
         end else if (beat && !at_limit) begin
            burst_cnt <= burst_cnt + 1'b1;
         end
      end
   end
   a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.gnt));
   a_rvalid_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.rvalid));
endmodule
